i2c_master_regs_q: RTL and testbench
====================================

# i2c_master_regs_q

Queued, parametrised register file for the I2C master. It decodes Wishbone write and read strobes into the prescale and control registers, a command/transmit queue and a receive FIFO. The queue head drives the byte controller's command and transmit byte. The block also produces the status register and a maskable interrupt. It sits between the Wishbone slave decoder and the I2C byte controller, and lets software queue several byte transfers without servicing every one.

## Interface
Parameters:
- PRER_W, 16, prescaler width; legal range 9..16.
- DEPTH, 4, command-queue and RX-FIFO depth; power of two, 2..16.
- LW, $clog2(DEPTH)+1, level-counter width (derived, do not override).

Ports (reset rst_i, asynchronous, active-low; clock wb_clk_i):
- wb_clk_i  in  1  system clock
- rst_i  in  1  asynchronous active-low reset
- wb_rst_i  in  1  synchronous active-high reset, same effect as rst_i
- wb_dat_i  in  16  write data
- wb_adr_i  in  4  register address
- wb_wacc  in  1  one-cycle write strobe
- wb_racc  in  1  one-cycle read strobe
- done  in  1  byte controller finished the head command
- i2c_al  in  1  arbitration lost
- i2c_busy  in  1  bus busy
- irxack  in  1  received ACK bit
- rxd_i  in  8  received byte, valid with done
- prer  out  PRER_W  clock prescaler
- ctr  out  8  control register
- cr  out  8  head command: [7:4] STA,STO,RD,WR, [3] ACK, [0] IACK pulse
- txr  out  8  head transmit byte
- rxr  out  8  RX FIFO head, 8'h00 when empty
- sr  out  8  status register
- cmd_lvl  out  LW  command-queue occupancy
- rx_lvl  out  LW  RX-FIFO occupancy
- irq_o  out  1  interrupt request

## Operation
Writes occur when wb_wacc is high:
- 0x0: prer[7:0] <= wb_dat_i[7:0].
- 0x2: prer[PRER_W-1:8] <= wb_dat_i[PRER_W-9:0].
- 0x4: ctr <= wb_dat_i[7:0]. ctr[7] is EN, ctr[6] is IEN, ctr[5] is QIE (queue-empty interrupt enable).
- 0x6: tx staging register <= wb_dat_i[7:0].
- 0x8: if ctr[7]=1, push {wb_dat_i[7:3], staging} into the command queue; ignored when ctr[7]=0. If wb_dat_i[0]=1, IACK pulses for one cycle independently of ctr[7], and nothing is queued.
- 0xA: bit0 flushes the command queue, bit1 flushes the RX FIFO, bit2 clears the overflow flag.

Reads and FIFO handling:
- wb_racc with adr 0x6 pops the RX FIFO. A pop when empty has no effect.
- cr[7:3] and txr come from the queue head; they are 0 when the queue is empty. cr[2:1] are always 0.
- done with a non-empty queue pops the head. If the head RD bit is 1, the same edge also pushes rxd_i into the RX FIFO.
- done with an empty queue is ignored.
- i2c_al flushes the entire command queue. The RX FIFO is kept.
- If a push and a pop hit the same FIFO in the same cycle, both take effect and the level is unchanged, including when the FIFO is full.
- A push to a full FIFO with no simultaneous pop is dropped and sets ovf. ovf is sticky until cleared by 0xA bit2.
- Flush has priority over a push in the same cycle.

Status and interrupt:
- al <= i2c_al | (al & ~(cmd push with STA)).
- rxack <= irxack.
- irq_flag <= (done | i2c_al | (QIE & pop leaving cmd_lvl=0) | irq_flag) & ~IACK. IACK wins over a same-cycle set.
- sr[7]=rxack, [6]=i2c_busy, [5]=al, [4]=ovf, [3]=cmd queue full, [2]=rx_lvl!=0, [1]=tip (cmd_lvl!=0), [0]=irq_flag.
- irq_o = irq_flag & ctr[6].

## Timing
Reset values:
- prer = all ones.
- ctr, cr, txr, rxr, staging, al, rxack, ovf and irq_flag = 0.
- Both levels = 0; both FIFOs empty.
- wb_rst_i produces the same values synchronously.

Latencies:
- A write or push at edge N is visible on the outputs after edge N.
- cr, txr, rxr, sr[4:1], cmd_lvl and rx_lvl decode combinationally from registered FIFO state.
- IACK (cr[0]) is high for exactly the cycle after the write.
- al, rxack and irq_flag have a one-cycle register delay from their inputs.
- Pointers wrap modulo DEPTH. Levels range 0..DEPTH.

## Configuration
- Macro I2C_RXFIFO_EN.
- Defined: the RX FIFO has DEPTH entries.
- Undefined: the RX path is a single holding register. rx_lvl is 0 or 1, a second received byte without an intervening pop sets ovf, and the command queue keeps DEPTH entries.

## Test plan
- Reset and prescale: reset, then write 0x0=0x34 and 0x2=0x12. Required: prer=0x1234; before the writes, prer=0xFFFF and sr=0x00.
- Queue fill: with ctr=0x80, stage 0xA5 and write 0x8=0x90, stage 0x5A and write 0x8=0x10. Required: cmd_lvl=2, cr=0x90, txr=0xA5. One done: cr=0x10, txr=0x5A. Second done: sr[1]=0, sr[0]=1.
- Overflow: push DEPTH+1 commands with no done. Required: cmd_lvl=DEPTH, sr[3]=1, sr[4]=1; the head is unchanged. Write 0xA=0x4: sr[4]=0.
- Read path: queue RD command 0x20; done with rxd_i=0xC3. Required: rx_lvl=1, rxr=0xC3. wb_racc at 0x6: rx_lvl=0, rxr=0x00.
- Arbitration loss: 3 commands queued, pulse i2c_al. Required: cmd_lvl=0, sr[5]=1, irq_o=1 when ctr=0xC0. Queue a STA command: sr[5]=0.
- Collisions: with the queue full, done and push in the same cycle. Required: level stays DEPTH, ovf=0. IACK together with done: irq_flag=0.

Source files
------------

// File: rtl/i2c_master_regs_q.sv
// i2c_master_regs_q: Wishbone register file for the I2C master with a command queue and RX path.
// Define I2C_RXFIFO_EN for a DEPTH-entry RX FIFO; otherwise received bytes use one holding register.
`timescale 1ns/1ps
module i2c_master_regs_q #(
    parameter int PRER_W = 16,
    parameter int DEPTH  = 4,
    parameter int LW     = $clog2(DEPTH) + 1
) (
    input  logic              wb_clk_i,
    input  logic              rst_i,
    input  logic              wb_rst_i,
    input  logic [15:0]       wb_dat_i,
    input  logic [3:0]        wb_adr_i,
    input  logic              wb_wacc,
    input  logic              wb_racc,
    input  logic              done,
    input  logic              i2c_al,
    input  logic              i2c_busy,
    input  logic              irxack,
    input  logic [7:0]        rxd_i,
    output logic [PRER_W-1:0] prer,
    output logic [7:0]        ctr,
    output logic [7:0]        cr,
    output logic [7:0]        txr,
    output logic [7:0]        rxr,
    output logic [7:0]        sr,
    output logic [LW-1:0]     cmd_lvl,
    output logic [LW-1:0]     rx_lvl,
    output logic              irq_o
);
    localparam int PW = LW - 1;
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

    logic [7:0]    staging;
    logic [12:0]   cmd_mem [DEPTH];
    logic [PW-1:0] cmd_wr, cmd_rd;
    logic [LW-1:0] cmd_cnt, cmd_cnt_nxt;
    logic          iack_q, al, rxack, ovf, irq_flag;

    logic wr_prer_lo, wr_prer_hi, wr_ctr, wr_txr, wr_cmd, wr_flush, rd_rx;
    assign wr_prer_lo = wb_wacc && (wb_adr_i == 4'h0);
    assign wr_prer_hi = wb_wacc && (wb_adr_i == 4'h2);
    assign wr_ctr     = wb_wacc && (wb_adr_i == 4'h4);
    assign wr_txr     = wb_wacc && (wb_adr_i == 4'h6);
    assign wr_cmd     = wb_wacc && (wb_adr_i == 4'h8);
    assign wr_flush   = wb_wacc && (wb_adr_i == 4'hA);
    assign rd_rx      = wb_racc && (wb_adr_i == 4'h6);

    // Entry layout: [12:8] = STA,STO,RD,WR,ACK, [7:0] = transmit byte
    logic [12:0] head;
    logic cmd_empty, cmd_full, cmd_push_req, cmd_pop, cmd_flush, cmd_push, cmd_drop;
    logic iack_set, qe_evt;

    assign head         = cmd_mem[cmd_rd];
    assign cmd_empty    = (cmd_cnt == '0);
    assign cmd_full     = (cmd_cnt == LVL_FULL);
    assign iack_set     = wr_cmd && wb_dat_i[0];
    assign cmd_push_req = wr_cmd && !wb_dat_i[0] && ctr[7];
    assign cmd_pop      = done && !cmd_empty;
    assign cmd_flush    = (wr_flush && wb_dat_i[0]) || i2c_al;
    assign cmd_push     = cmd_push_req && !cmd_flush && (!cmd_full || cmd_pop);
    assign cmd_drop     = cmd_push_req && !cmd_flush && cmd_full && !cmd_pop;

    always_comb begin
        cmd_cnt_nxt = cmd_cnt;
        if (cmd_flush)
            cmd_cnt_nxt = '0;
        else if (cmd_push && !cmd_pop)
            cmd_cnt_nxt = cmd_cnt + 1'b1;
        else if (cmd_pop && !cmd_push)
            cmd_cnt_nxt = cmd_cnt - 1'b1;
    end

    assign qe_evt = ctr[5] && cmd_pop && (cmd_cnt_nxt == '0);

    logic       rx_push_req, rx_pop, rx_flush, rx_push, rx_drop, rx_full, rx_empty;
    logic [7:0] rx_head;

    assign rx_push_req = cmd_pop && head[10];
    assign rx_pop      = rd_rx && !rx_empty;
    assign rx_flush    = wr_flush && wb_dat_i[1];
    assign rx_push     = rx_push_req && !rx_flush && (!rx_full || rx_pop);
    assign rx_drop     = rx_push_req && !rx_flush && rx_full && !rx_pop;

    always_ff @(posedge wb_clk_i or negedge rst_i) begin
        if (!rst_i) begin
            prer     <= '1;
            ctr      <= '0;
            staging  <= '0;
            cmd_wr   <= '0;
            cmd_rd   <= '0;
            cmd_cnt  <= '0;
            iack_q   <= 1'b0;
            al       <= 1'b0;
            rxack    <= 1'b0;
            ovf      <= 1'b0;
            irq_flag <= 1'b0;
        end else if (wb_rst_i) begin
            prer     <= '1;
            ctr      <= '0;
            staging  <= '0;
            cmd_wr   <= '0;
            cmd_rd   <= '0;
            cmd_cnt  <= '0;
            iack_q   <= 1'b0;
            al       <= 1'b0;
            rxack    <= 1'b0;
            ovf      <= 1'b0;
            irq_flag <= 1'b0;
        end else begin
            if (wr_prer_lo) prer[7:0] <= wb_dat_i[7:0];
            if (wr_prer_hi) prer[PRER_W-1:8] <= wb_dat_i[PRER_W-9:0];
            if (wr_ctr) ctr <= wb_dat_i[7:0];
            if (wr_txr) staging <= wb_dat_i[7:0];
            iack_q <= iack_set;
            if (cmd_flush) begin
                cmd_wr <= '0;
                cmd_rd <= '0;
            end else begin
                if (cmd_push) cmd_wr <= cmd_wr + 1'b1;
                if (cmd_pop)  cmd_rd <= cmd_rd + 1'b1;
            end
            cmd_cnt  <= cmd_cnt_nxt;
            al       <= i2c_al | (al & ~(cmd_push_req & wb_dat_i[7]));
            rxack    <= irxack;
            // A drop in the same cycle as a clear leaves the flag set so the loss is never hidden
            ovf      <= (ovf & ~(wr_flush & wb_dat_i[2])) | cmd_drop | rx_drop;
            irq_flag <= (done | i2c_al | qe_evt | irq_flag) & ~iack_q;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (cmd_push) cmd_mem[cmd_wr] <= {wb_dat_i[7:3], staging};
    end

`ifdef I2C_RXFIFO_EN
    logic [7:0]    rx_mem [DEPTH];
    logic [PW-1:0] rx_wr, rx_rd;
    logic [LW-1:0] rx_cnt;

    assign rx_empty = (rx_cnt == '0);
    assign rx_full  = (rx_cnt == LVL_FULL);
    assign rx_head  = rx_mem[rx_rd];
    assign rx_lvl   = rx_cnt;

    always_ff @(posedge wb_clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rx_wr  <= '0;
            rx_rd  <= '0;
            rx_cnt <= '0;
        end else if (wb_rst_i || rx_flush) begin
            rx_wr  <= '0;
            rx_rd  <= '0;
            rx_cnt <= '0;
        end else begin
            if (rx_push) rx_wr <= rx_wr + 1'b1;
            if (rx_pop)  rx_rd <= rx_rd + 1'b1;
            if (rx_push && !rx_pop)
                rx_cnt <= rx_cnt + 1'b1;
            else if (rx_pop && !rx_push)
                rx_cnt <= rx_cnt - 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (rx_push) rx_mem[rx_wr] <= rxd_i;
    end
`else
    logic [7:0] rx_hold;
    logic       rx_valid;

    assign rx_empty = !rx_valid;
    assign rx_full  = rx_valid;
    assign rx_head  = rx_hold;
    assign rx_lvl   = {{(LW-1){1'b0}}, rx_valid};

    // A same-cycle pop and push replaces the byte and keeps the register occupied
    always_ff @(posedge wb_clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rx_hold  <= '0;
            rx_valid <= 1'b0;
        end else if (wb_rst_i || rx_flush) begin
            rx_hold  <= '0;
            rx_valid <= 1'b0;
        end else if (rx_push) begin
            rx_hold  <= rxd_i;
            rx_valid <= 1'b1;
        end else if (rx_pop) begin
            rx_valid <= 1'b0;
        end
    end
`endif

    assign cr      = {(cmd_empty ? 5'b0 : head[12:8]), 2'b00, iack_q};
    assign txr     = cmd_empty ? 8'h00 : head[7:0];
    assign rxr     = rx_empty ? 8'h00 : rx_head;
    assign cmd_lvl = cmd_cnt;
    assign sr      = {rxack, i2c_busy, al, ovf, cmd_full, !rx_empty, !cmd_empty, irq_flag};
    assign irq_o   = irq_flag & ctr[6];
endmodule

// File: tb/tb_i2c_master_regs_q.sv
// tb_i2c_master_regs_q: scoreboard bench for i2c_master_regs_q; queue models hold the expected
// command heads and received bytes, compared when the DUT pops them.
`timescale 1ns/1ps
module tb_i2c_master_regs_q;
    localparam int PRER_W = 16;
    localparam int DEPTH  = 4;
    localparam int LW     = $clog2(DEPTH) + 1;

    logic              wb_clk_i = 1'b0;
    logic              rst_i = 1'b0;
    logic              wb_rst_i = 1'b0;
    logic [15:0]       wb_dat_i = '0;
    logic [3:0]        wb_adr_i = '0;
    logic              wb_wacc = 1'b0;
    logic              wb_racc = 1'b0;
    logic              done = 1'b0;
    logic              i2c_al = 1'b0;
    logic              i2c_busy = 1'b0;
    logic              irxack = 1'b0;
    logic [7:0]        rxd_i = '0;
    logic [PRER_W-1:0] prer;
    logic [7:0]        ctr, cr, txr, rxr, sr;
    logic [LW-1:0]     cmd_lvl, rx_lvl;
    logic              irq_o;

    int tests_run = 0;
    int tests_failed = 0;
    logic [15:0] cmd_model[$];
    logic [7:0]  rx_model[$];
    logic        en_model = 1'b0;

    i2c_master_regs_q #(.PRER_W(PRER_W), .DEPTH(DEPTH)) dut (
        .wb_clk_i(wb_clk_i), .rst_i(rst_i), .wb_rst_i(wb_rst_i),
        .wb_dat_i(wb_dat_i), .wb_adr_i(wb_adr_i), .wb_wacc(wb_wacc), .wb_racc(wb_racc),
        .done(done), .i2c_al(i2c_al), .i2c_busy(i2c_busy), .irxack(irxack), .rxd_i(rxd_i),
        .prer(prer), .ctr(ctr), .cr(cr), .txr(txr), .rxr(rxr), .sr(sr),
        .cmd_lvl(cmd_lvl), .rx_lvl(rx_lvl), .irq_o(irq_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic wbWrite(input logic [3:0] adr, input logic [15:0] dat);
        wb_adr_i = adr;
        wb_dat_i = dat;
        wb_wacc  = 1'b1;
        tick();
        wb_wacc  = 1'b0;
    endtask

    // Compares the visible head with the model front, then retires it on the coming done
    task automatic retireHead(input string tag, input logic [7:0] rxd);
        logic [15:0] exp_head;
        exp_head = (cmd_model.size() != 0) ? cmd_model[0] : 16'h0000;
        checkOutput({tag, "_cr"}, {8'h00, cr & 8'hF8}, {8'h00, exp_head[15:8]});
        checkOutput({tag, "_txr"}, {8'h00, txr}, {8'h00, exp_head[7:0]});
        if (cmd_model.size() != 0) begin
            void'(cmd_model.pop_front());
            if (exp_head[13]) rx_model.push_back(rxd);
        end
    endtask

    task automatic doneCycle(input string tag, input logic [7:0] rxd);
        retireHead(tag, rxd);
        done  = 1'b1;
        rxd_i = rxd;
        tick();
        done  = 1'b0;
    endtask

    task automatic applyStimulus(input logic [7:0] cmd, input logic [7:0] tx, input logic with_done);
        wbWrite(4'h6, {8'h00, tx});
        if (with_done) begin
            retireHead("coll_head", 8'h00);
            done  = 1'b1;
            rxd_i = 8'h00;
        end
        wb_adr_i = 4'h8;
        wb_dat_i = {8'h00, cmd};
        wb_wacc  = 1'b1;
        tick();
        wb_wacc  = 1'b0;
        done     = 1'b0;
        if (en_model && cmd_model.size() < DEPTH)
            cmd_model.push_back({cmd[7:3], 3'b000, tx});
    endtask

    task automatic readRx(input string tag);
        logic [7:0] exp_rx;
        exp_rx = (rx_model.size() != 0) ? rx_model.pop_front() : 8'h00;
        checkOutput(tag, {8'h00, rxr}, {8'h00, exp_rx});
        wb_adr_i = 4'h6;
        wb_racc  = 1'b1;
        tick();
        wb_racc  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(posedge wb_clk_i);
        #1;
        rst_i = 1'b1;
        tick();
        checkOutput("rst_prer", prer, 16'hFFFF);
        checkOutput("rst_sr", {8'h00, sr}, 16'h0000);
        checkOutput("rst_ctr", {8'h00, ctr}, 16'h0000);
        checkOutput("rst_cr", {8'h00, cr}, 16'h0000);
        checkOutput("rst_lvls", {8'h00, 4'(cmd_lvl), 4'(rx_lvl)}, 16'h0000);
        checkOutput("rst_irq", 16'(irq_o), 16'h0000);

        wbWrite(4'h0, 16'h0034);
        wbWrite(4'h2, 16'h0012);
        checkOutput("prer", prer, 16'h1234);

        wbWrite(4'h4, 16'h0080);
        en_model = 1'b1;
        applyStimulus(8'h90, 8'hA5, 1'b0);
        applyStimulus(8'h10, 8'h5A, 1'b0);
        checkOutput("fill_lvl", 16'(cmd_lvl), 16'd2);
        doneCycle("fill_d1", 8'h00);
        doneCycle("fill_d2", 8'h00);
        checkOutput("fill_sr", {8'h00, sr}, 16'h0001);
        wbWrite(4'h8, 16'h0001);
        checkOutput("iack_cr", {8'h00, cr}, 16'h0001);
        tick();
        checkOutput("iack_clr", {8'h00, sr}, 16'h0000);

        for (int i = 0; i <= DEPTH; i++)
            applyStimulus(8'h10, 8'(i), 1'b0);
        checkOutput("ovf_lvl", 16'(cmd_lvl), 16'(DEPTH));
        checkOutput("ovf_full", 16'(sr[3]), 16'd1);
        checkOutput("ovf_flag", 16'(sr[4]), 16'd1);
        retireHead("ovf_head", 8'h00);
        cmd_model.push_front({5'b00010, 3'b000, 8'h00});
        wbWrite(4'hA, 16'h0004);
        checkOutput("ovf_clr", 16'(sr[4]), 16'd0);
        checkOutput("ovf_lvl2", 16'(cmd_lvl), 16'(DEPTH));

        applyStimulus(8'h10, 8'h77, 1'b1);
        checkOutput("coll_lvl", 16'(cmd_lvl), 16'(DEPTH));
        checkOutput("coll_ovf", 16'(sr[4]), 16'd0);
        checkOutput("coll_irq_pre", 16'(sr[0]), 16'd1);
        wbWrite(4'h8, 16'h0001);
        doneCycle("iack_done", 8'h00);
        checkOutput("iack_done_irq", 16'(sr[0]), 16'd0);
        checkOutput("iack_done_lvl", 16'(cmd_lvl), 16'(DEPTH - 1));

        wbWrite(4'hA, 16'h0001);
        cmd_model.delete();
        checkOutput("flush_lvl", 16'(cmd_lvl), 16'd0);
        doneCycle("empty_done", 8'h55);
        checkOutput("empty_lvls", {8'h00, 4'(cmd_lvl), 4'(rx_lvl)}, 16'h0000);

        applyStimulus(8'h20, 8'h00, 1'b0);
        doneCycle("rd_head", 8'hC3);
        checkOutput("rd_lvl", 16'(rx_lvl), 16'd1);
        readRx("rd_rxr");
        checkOutput("rd_lvl0", 16'(rx_lvl), 16'd0);
        checkOutput("rd_rxr0", {8'h00, rxr}, 16'h0000);

        wbWrite(4'h4, 16'h00C0);
        wbWrite(4'h8, 16'h0001);
        tick();
        checkOutput("al_irq_pre", 16'(irq_o), 16'd0);
        for (int i = 1; i <= 3; i++)
            applyStimulus(8'h10, 8'(i), 1'b0);
        checkOutput("al_lvl3", 16'(cmd_lvl), 16'd3);
        i2c_al = 1'b1;
        tick();
        i2c_al = 1'b0;
        cmd_model.delete();
        checkOutput("al_lvl", 16'(cmd_lvl), 16'd0);
        checkOutput("al_sr", 16'(sr[5]), 16'd1);
        checkOutput("al_irq", 16'(irq_o), 16'd1);
        applyStimulus(8'h80, 8'h42, 1'b0);
        checkOutput("al_sta", 16'(sr[5]), 16'd0);
        retireHead("al_head", 8'h00);
        cmd_model.push_front({5'b10000, 3'b000, 8'h42});

        irxack = 1'b1;
        i2c_busy = 1'b1;
        tick();
        checkOutput("rxack_busy", {14'h0, sr[7:6]}, 16'h0003);
        irxack = 1'b0;
        i2c_busy = 1'b0;
        wb_rst_i = 1'b1;
        tick();
        wb_rst_i = 1'b0;
        checkOutput("srst_prer", prer, 16'hFFFF);
        checkOutput("srst_ctr", {8'h00, ctr}, 16'h0000);
        checkOutput("srst_lvl", 16'(cmd_lvl), 16'd0);
        checkOutput("srst_sr", {8'h00, sr}, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
